// File: rtl/depacketizer_da.sv
// depacketizer_da: reassembles fixed-length NoC packets into user data
// plus the return destination and VC carried by the sender.
module depacketizer_da #(
    parameter int ADDRESS_WIDTH      = 4,
    parameter int VC_ADDRESS_WIDTH   = 1,
    parameter int WIDTH_IN           = 36,
    parameter int WIDTH_OUT          = 12,
    parameter int DEPACKETIZER_WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH_IN-1:0]         data_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [WIDTH_OUT-1:0]        data_out,
    output logic [ADDRESS_WIDTH-1:0]    ret_dst_out,
    output logic [VC_ADDRESS_WIDTH-1:0] ret_vc_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        drop_out
);

    localparam int HPW = WIDTH_IN - 3 - ADDRESS_WIDTH - VC_ADDRESS_WIDTH;
    localparam int BPW = WIDTH_IN - 3 - VC_ADDRESS_WIDTH;
    localparam int PW  = WIDTH_OUT + ADDRESS_WIDTH + VC_ADDRESS_WIDTH;
    localparam int TOT = HPW + (DEPACKETIZER_WIDTH - 1) * BPW;
    localparam logic [1:0] LAST = 2'(DEPACKETIZER_WIDTH - 1);

    if (TOT < PW || DEPACKETIZER_WIDTH < 1 || DEPACKETIZER_WIDTH > 4) begin : g_param_check
        $fatal(1, "depacketizer_da: payload too narrow or bad flit count");
    end

    typedef enum logic {
        ASSEMBLE = 1'b0,
        HOLD     = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   pkt_q, pkt_d;
    logic            drop_q, drop_d;

    logic            f_valid, f_head, f_tail, accept;
    logic [PW+HPW-1:0] head_ext;
    logic [PW+BPW-1:0] body_ext;
    logic            unused_bits;

    assign f_valid  = data_in[WIDTH_IN-1];
    assign f_head   = data_in[WIDTH_IN-2];
    assign f_tail   = data_in[WIDTH_IN-3];
    assign accept   = valid_in & ready_out;
    // Earlier payload pieces shift up; only the low PW bits survive.
    assign head_ext = {{PW{1'b0}}, data_in[HPW-1:0]};
    assign body_ext = {acc_q, data_in[BPW-1:0]};

    assign unused_bits = ^{data_in[WIDTH_IN-4 -: VC_ADDRESS_WIDTH],
                           head_ext[PW+HPW-1:PW],
                           body_ext[PW+BPW-1:PW]};

    // State, counter, assembly and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ASSEMBLE;
            cnt_q   <= 2'd0;
            acc_q   <= '0;
            pkt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
        end
    end

    // Next state: a retiring packet frees the slot for a same-cycle flit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        pkt_d   = pkt_q;
        drop_d  = 1'b0;
        if (state_q == HOLD && ready_in) begin
            state_d = ASSEMBLE;
        end
        if (accept && f_valid) begin
            if (f_head) begin
                if (cnt_q != 2'd0) begin
                    drop_d = 1'b1;
                end
                if (DEPACKETIZER_WIDTH == 1) begin
                    cnt_d = 2'd0;
                    if (f_tail) begin
                        pkt_d   = head_ext[PW-1:0];
                        state_d = HOLD;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else begin
                    acc_d = head_ext[PW-1:0];
                    cnt_d = 2'd1;
                end
            end else if (cnt_q == 2'd0) begin
                drop_d = 1'b1;
            end else if (f_tail != (cnt_q == LAST)) begin
                drop_d = 1'b1;
                cnt_d  = 2'd0;
            end else if (cnt_q == LAST) begin
                pkt_d   = body_ext[PW-1:0];
                state_d = HOLD;
                cnt_d   = 2'd0;
            end else begin
                acc_d = body_ext[PW-1:0];
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    // Outputs: handshake flags from state, fields from the packet register.
    always_comb begin
        ready_out   = (state_q == ASSEMBLE) | ready_in;
        valid_out   = (state_q == HOLD);
        drop_out    = drop_q;
        data_out    = pkt_q[WIDTH_OUT-1:0];
        ret_vc_out  = pkt_q[WIDTH_OUT +: VC_ADDRESS_WIDTH];
        ret_dst_out = pkt_q[PW-1 -: ADDRESS_WIDTH];
    end

endmodule
